// File: rtl/adc_ser_pkg.sv
// Shared constants, counter widths and FSM state type for the ADC frame serializer.
package adc_ser_pkg;

    localparam int NUM_CH     = 32;
    localparam int BITS_ADC   = 12;
    localparam int FRAME_BITS = NUM_CH * BITS_ADC;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BIT_CNT_W = cnt_w(BITS_ADC);
    localparam int CH_CNT_W  = cnt_w(NUM_CH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/ser_frame_cnt.sv
// Nested bit/channel counter. The counters always index the bit currently on the serial output.
module ser_frame_cnt
    import adc_ser_pkg::*;
#(
    parameter int  NUM_CH   = adc_ser_pkg::NUM_CH,
    parameter int  BITS_ADC = adc_ser_pkg::BITS_ADC,
    localparam int BIT_W    = cnt_w(BITS_ADC),
    localparam int CH_W     = cnt_w(NUM_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [BIT_W-1:0] bit_cnt,
    output logic [CH_W-1:0]  ch_cnt,
    output logic             last
);

    logic bit_wrap;
    logic ch_wrap;

    assign bit_wrap = (bit_cnt == BIT_W'(BITS_ADC - 1));
    assign ch_wrap  = (ch_cnt == CH_W'(NUM_CH - 1));
    assign last     = bit_wrap && ch_wrap;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            bit_cnt <= '0;
            ch_cnt  <= '0;
        end else if (en) begin
            if (bit_wrap) begin
                bit_cnt <= '0;
                ch_cnt  <= ch_wrap ? '0 : ch_cnt + 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_frame_serializer.sv
// Captures all ADC channel words and shifts them out LSB first, channel 0 first, under an active-low strobe.
// Optional build macro SER_TEST_PATTERN_EN adds a test_mode input that loads a fixed per-channel pattern.
module adc_frame_serializer
    import adc_ser_pkg::*;
#(
    parameter int  NUM_CH   = adc_ser_pkg::NUM_CH,
    parameter int  BITS_ADC = adc_ser_pkg::BITS_ADC,
    localparam int FRAME_W  = NUM_CH * BITS_ADC,
    localparam int BIT_W    = cnt_w(BITS_ADC),
    localparam int CH_W     = cnt_w(NUM_CH),
    localparam int IDX_W    = cnt_w(FRAME_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef SER_TEST_PATTERN_EN
    input  logic               test_mode,
`endif
    input  logic [FRAME_W-1:0] adc_data,
    output logic               s_data,
    output logic               data_valid,
    output logic               busy,
    output logic               done
);

    ser_state_t         state;
    ser_state_t         state_nxt;
    logic [FRAME_W-1:0] shadow_p0;
    logic [FRAME_W-1:0] cap_data;
    logic [BIT_W-1:0]   bit_cnt;
    logic [CH_W-1:0]    ch_cnt;
    logic [IDX_W-1:0]   nxt_idx;
    logic               last;
    logic               capture;
    logic               cnt_en;
    logic               s_data_nxt;
    logic               data_valid_nxt;
    logic               done_nxt;

`ifdef SER_TEST_PATTERN_EN
    function automatic logic [FRAME_W-1:0] test_pattern();
        logic [FRAME_W-1:0] p;
        logic [4:0]         k5;
        p = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            k5 = 5'(k);
            p[k*BITS_ADC +: 8] = 8'hA0 | {3'b000, k5};
        end
        return p;
    endfunction

    localparam logic [FRAME_W-1:0] PATTERN = test_pattern();

    assign cap_data = test_mode ? PATTERN : adc_data;
`else
    assign cap_data = adc_data;
`endif

    ser_frame_cnt #(
        .NUM_CH   (NUM_CH),
        .BITS_ADC (BITS_ADC)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (capture),
        .en      (cnt_en),
        .bit_cnt (bit_cnt),
        .ch_cnt  (ch_cnt),
        .last    (last)
    );

    // Outputs are registered, so the mux looks one bit ahead of the counters.
    assign nxt_idx = IDX_W'(ch_cnt) * IDX_W'(BITS_ADC) + IDX_W'(bit_cnt) + 1'b1;
    assign busy    = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        capture        = 1'b0;
        cnt_en         = 1'b0;
        s_data_nxt     = 1'b0;
        data_valid_nxt = 1'b1;
        done_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture        = 1'b1;
                    s_data_nxt     = cap_data[0];
                    data_valid_nxt = 1'b0;
                end
            end
            SHIFT: begin
                cnt_en = 1'b1;
                if (last) begin
                    done_nxt = 1'b1;
                end else begin
                    s_data_nxt     = shadow_p0[nxt_idx];
                    data_valid_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Capture / output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_p0  <= '0;
            s_data     <= 1'b0;
            data_valid <= 1'b1;
            done       <= 1'b0;
        end else begin
            if (capture) begin
                shadow_p0 <= cap_data;
            end
            s_data     <= s_data_nxt;
            data_valid <= data_valid_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_adc_frame_serializer.sv
// Randomized scoreboard bench: a deserializer model rebuilds each frame and compares it with the captured words.
`timescale 1ns/1ps
module tb_adc_frame_serializer;

    localparam int NCH = 32;
    localparam int BW  = 12;
    localparam int FW  = NCH * BW;

    typedef struct {
        logic [FW-1:0] data;
        int            len;
        bit            done_exp;
        int            gap;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [FW-1:0] adc_data;
    logic          s_data;
    logic          data_valid;
    logic          busy;
    logic          done;
`ifdef SER_TEST_PATTERN_EN
    logic          test_mode;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    bit   mon_en = 1'b0;
    bit   mon_bits[$];
    int   run_len = 0;
    int   idle_cnt = 0;
    exp_t e;
    logic [BW-1:0] w_rx;

    adc_frame_serializer #(
        .NUM_CH   (NCH),
        .BITS_ADC (BW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
`ifdef SER_TEST_PATTERN_EN
        .test_mode  (test_mode),
`endif
        .adc_data   (adc_data),
        .s_data     (s_data),
        .data_valid (data_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] rand_bus();
        logic [FW-1:0] r;
        for (int i = 0; i < FW; i += 32) r[i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [FW-1:0] words_bus(input logic [BW-1:0] base, input bit xor_idx);
        logic [FW-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*BW +: BW] = xor_idx ? (base ^ BW'(k)) : base;
        return r;
    endfunction

    task automatic push_exp(input logic [FW-1:0] d, input int len, input bit dn, input int gap);
        exp_t x;
        x.data = d; x.len = len; x.done_exp = dn; x.gap = gap;
        q.push_back(x);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_s_data"}, s_data, 0);
        chk({tag, "_data_valid"}, data_valid, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Issues one frame starting at the next edge and returns in its done cycle.
    task automatic run_frame(input logic [FW-1:0] d, input int gap);
        adc_data = d;
        start = 1'b1;
        push_exp(d, FW, 1'b1, gap);
        tick();
        start = 1'b0;
        adc_data = rand_bus();
        repeat (FW) tick();
    endtask

    // Deserializer model and scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy_vs_strobe", busy, !data_valid);
            if (data_valid === 1'b0) begin
                if (run_len == 0 && q.size() > 0 && q[0].gap >= 0)
                    chk("idle_gap", idle_cnt, q[0].gap);
                mon_bits.push_back(s_data);
                run_len++;
                chk("done_in_frame", done, 0);
            end else begin
                chk("idle_s_data", s_data, 0);
                if (run_len > 0) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0d bits expected none", run_len);
                    end else begin
                        e = q.pop_front();
                        chk("frame_len", run_len, e.len);
                        chk("done_after_frame", done, e.done_exp);
                        for (int k = 0; k < run_len / BW && k < NCH; k++) begin
                            for (int b = 0; b < BW; b++) w_rx[b] = mon_bits[k*BW + b];
                            chk($sformatf("ch%0d_word", k), w_rx, e.data[k*BW +: BW]);
                        end
                    end
                    run_len = 0;
                    mon_bits.delete();
                    idle_cnt = 1;
                end else begin
                    chk("idle_done", done, 0);
                    idle_cnt++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [FW-1:0] d;
        int extra;

        rst = 1'b1;
        start = 1'b1;
`ifdef SER_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        d = '0;
        d[0] = 1'b1;
        adc_data = d;
        tick();
        mon_en = 1'b1;
        check_reset_vals("rst_c1");
        tick();
        check_reset_vals("rst_c2");
        tick();
        check_reset_vals("rst_c3");

        // Start still high when reset releases: first frame begins here.
        rst = 1'b0;
        push_exp(d, FW, 1'b1, -1);
        tick();
        chk("first_bit_s_data", s_data, 1);
        chk("first_bit_strobe", data_valid, 0);
        chk("first_bit_busy", busy, 1);
        start = 1'b0;
        repeat (FW) tick();
        chk("done_pulse", done, 1);

        d = '0;
        d[FW-1] = 1'b1;
        run_frame(d, 1);
        run_frame(words_bus(12'hA50, 1'b1), 1);

        // Isolation: flip the bus and re-request while shifting.
        d = rand_bus();
        adc_data = d;
        start = 1'b1;
        push_exp(d, FW, 1'b1, 1);
        tick();
        start = 1'b0;
        repeat (99) tick();
        adc_data = ~d;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (FW - 100) tick();

        // Start held high across three frames.
        start = 1'b1;
        for (int f = 0; f < 3; f++) begin
            d = rand_bus();
            adc_data = d;
            push_exp(d, FW, 1'b1, 1);
            tick();
            adc_data = rand_bus();
            repeat (FW) tick();
        end
        start = 1'b0;

        for (int r = 0; r < 3; r++) begin
            extra = $urandom_range(0, 3);
            repeat (extra) tick();
            run_frame(rand_bus(), 1 + extra);
        end

        // Reset mid-frame after 150 bits.
        tick();
        d = rand_bus();
        adc_data = d;
        start = 1'b1;
        push_exp(d, 150, 1'b0, -1);
        tick();
        start = 1'b0;
        repeat (149) tick();
        rst = 1'b1;
        tick();
        check_reset_vals("abort");
        rst = 1'b0;
        tick();
        check_reset_vals("post_abort");

        run_frame(rand_bus(), -1);

`ifdef SER_TEST_PATTERN_EN
        d = '0;
        for (int k = 0; k < NCH; k++) d[k*BW +: BW] = 12'h0A0 | BW'(k % 32);
        test_mode = 1'b1;
        adc_data = rand_bus();
        start = 1'b1;
        push_exp(d, FW, 1'b1, 1);
        tick();
        start = 1'b0;
        test_mode = 1'b0;
        repeat (FW) tick();
`endif

        repeat (5) tick();
        chk("scoreboard_empty", q.size(), 0);
        chk("no_open_frame", run_len, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
